rtfitanium_pitn: RTL and testbench
==================================

Name: rtfItanium_pitn

Overview:
- Parametrised programmable interval timer: NCH independent down-counters of CW bits, on the same 32-bit slave bus as the other rtfItanium peripherals.
- Per channel: PWM/pulse output, external clock and gate inputs with on-chip synchronisers, and three count modes (continuous, one-shot, gate-retriggered one-shot).
- Adds a maskable terminal-count interrupt and a global sync register, so any subset of channels can be loaded or started on the same clock.

Parameters:
- NCH, 3, number of channels, 1..8.
- CW, 32, counter width in bits, 8..32; register reads are zero-extended to 32 bits.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- cs_i  in  1  chip select.
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- ack_o  out  1  bus acknowledge.
- we_i  in  1  write enable.
- sel_i  in  4  byte selects.
- adr_i  in  8  byte address; bits [1:0] are ignored.
- dat_i  in  32  write data.
- dat_o  out  32  read data, registered.
- clk_x  in  NCH  external count clocks, asynchronous.
- gate  in  NCH  gate inputs, asynchronous.
- out  out  NCH  channel outputs.
- irq_o  out  1  OR of (irq_stat & irq_en).

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - count, max, ont, irq_stat, irq_en and dat_o all go to 0.
  - Control bits: ce=0, ld=0, ar=1, xc=0, ge=0, mode=00.
  - out=0, irq_o=0, ack_o=0.
  - Reset mid-count aborts immediately. After release, nothing counts until software sets ce.
- Bus:
  - cs = cs_i & cyc_i & stb_i.
  - Writes: ack_o asserts in the same cycle as cs.
  - Reads: ack_o asserts one cycle after cs, with dat_o valid, and holds while cs stays high.
  - ack_o drops combinationally when cs drops.
  - Writes honour sel_i per byte.
- Per-channel registers, channel n at 0x10*n, n<NCH:
  - +0x0 count, read-only.
  - +0x4 max count, read-write.
  - +0x8 on time, read-write.
  - +0xC control, read-write:
    - bit0 ld: self-clearing, reads 0.
    - bit1 ce: enable.
    - bit2 ar: auto-reload.
    - bit3 xc: external clock.
    - bit4 ge: gate enable.
    - bits6:5 mode: 00 continuous, 01 one-shot, 10 gate-retrigger, 11 reserved (behaves as 00).
- Global registers:
  - 0x80 irq_stat: bit n set by channel n terminal count; write-1-to-clear.
  - 0x84 irq_en.
  - 0x88 sync, write-only, reads 0: bit n = ld for channel n, bit 8+n = set ce for channel n, both applied in the same cycle.
- Unmapped addresses: reads return 0, writes are ignored. Writing max or ont does not alter count until the next load or reload.
- Synchronisers: clk_x and gate each pass through a 2-flop synchroniser plus rising-edge detector, giving 3 cycles of latency from the pin to the internal pulse.
- Tick condition: ce & (xc ? clk_x_pe : 1) & (ge ? gate_sync : 1).
  - In mode 10 the gate level is not used for the tick.
- Priority per channel, highest first:
  1. ld: count <= max. Counting resumes on the following tick.
  2. Mode 10 gate rising edge: count <= max, ce <= 1.
  3. Tick, evaluated against the current count:
     - count==ont (before decrement): out <= 1.
     - count==0: out <= 0, irq_stat[n] <= 1. Then:
       - if ar=1 and mode=00: count <= max.
       - otherwise: count stays 0 and ce <= 0 (one-shot done).
     - else: count <= count-1. Wrap from 0 to all-ones never occurs.
- Simultaneous events:
  - A terminal-count set of irq_stat in the same cycle as a W1C to that bit: the set wins.
  - A per-channel control write in the same cycle as a sync write: the sync bits are ORed into ld/ce.
  - A ce=1 write in the same cycle as an internal ce clear: the write wins.
- Output timing: out and irq_o are registered and change the cycle after the tick; irq_o additionally passes through one flop after the AND.

Decomposition:
- Package rtfItanium_pit_pkg holds:
  - the mode enum pit_mode_t (PM_CONT, PM_ONESHOT, PM_RETRIG);
  - register offset constants PIT_CNT, PIT_MAX, PIT_ONT, PIT_CTRL, PIT_IRQS, PIT_IRQE, PIT_SYNC;
  - the control bit index constants.
- Sub-module rtfItanium_pit_chan, parameter CW: one channel's counter, control, synchronisers and output. The top level generates NCH instances and holds the bus decode, read mux and global registers.

Test Plan:
- max=5, ont=2, ce=1, ar=1, mode 00, ld via sync → count sequence 5,4,3,2,1,0,5…; out high while count is 1..0; irq_stat[0] sets every 6 ticks; irq_o=1 with irq_en[0]=1.
- mode 01, max=3 → counts 3,2,1,0, then stays 0 with ce read back 0; irq_stat[0]=1; writing 1 to 0x80 clears it and irq_o falls.
- mode 10, ge=1, max=4 → gate edge loads 4 and starts; a second gate edge at count=2 reloads 4; terminal count reached 5 ticks after the last edge.
- xc=1, clk_x toggling every 8 cycles → count decrements once per clk_x rising edge, first decrement 3 cycles after the first edge; clk_x held high → no further decrements.
- NCH=3: sync write 0x0000_0707 with max0=10, max1=20, max2=30 → all three loaded and enabled in the same cycle; counts read 9, 19, 29 after one tick.
- rst_ni pulsed low mid-count → all outputs 0, count 0, ar=1 immediately without any clock edge; a read of 0x0C returns 0x04; a read of 0x90 returns 0.

Source files
------------

// File: rtl/rtfitanium_pitn_pkg.sv
// Shared types and constants for the programmable interval timer.
// Holds the count-mode encoding, register offsets, control bit positions
// and a byte-lane merge helper used by the bus write path.
package rtfitanium_pitn_pkg;

  typedef enum logic [1:0] {
    PM_CONT    = 2'b00,
    PM_ONESHOT = 2'b01,
    PM_RETRIG  = 2'b10
  } pit_mode_t;

  // Per-channel offsets within a 16-byte channel window
  localparam logic [3:0] PIT_CNT  = 4'h0;
  localparam logic [3:0] PIT_MAX  = 4'h4;
  localparam logic [3:0] PIT_ONT  = 4'h8;
  localparam logic [3:0] PIT_CTRL = 4'hC;

  // Global register addresses
  localparam logic [7:0] PIT_IRQS = 8'h80;
  localparam logic [7:0] PIT_IRQE = 8'h84;
  localparam logic [7:0] PIT_SYNC = 8'h88;

  // Control register bit positions
  localparam int unsigned CTRL_LD      = 0;
  localparam int unsigned CTRL_CE      = 1;
  localparam int unsigned CTRL_AR      = 2;
  localparam int unsigned CTRL_XC      = 3;
  localparam int unsigned CTRL_GE      = 4;
  localparam int unsigned CTRL_MODE_LO = 5;
  localparam int unsigned CTRL_MODE_HI = 6;
  localparam int unsigned CTRL_W       = 7;

  // Replace only the byte lanes selected by sel
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rtfitanium_pitn_chan.sv
// One timer channel: down-counter, control bits, input synchronisers, output.
// Ports:
//   clk_i/rst_ni             clock, async active-low reset
//   clk_x_i/gate_i           asynchronous external clock and gate pins
//   wr_max_i/wr_ont_i/wr_ctrl_i + wdat_*_i   register writes (lanes pre-merged)
//   ld_sync_i/ce_sync_i      global sync strobes
//   count_o/max_o/ont_o/ctrl_o  register readback (ctrl ld bit reads 0)
//   out_o                    registered channel output
//   tc_c_o                   combinational terminal-count pulse
module rtfitanium_pitn_chan
  import rtfitanium_pitn_pkg::*;
#(
  parameter int unsigned CW = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clk_x_i,
  input  logic              gate_i,
  input  logic              wr_max_i,
  input  logic              wr_ont_i,
  input  logic              wr_ctrl_i,
  input  logic [CW-1:0]     wdat_max_i,
  input  logic [CW-1:0]     wdat_ont_i,
  input  logic [CTRL_W-1:0] wdat_ctrl_i,
  input  logic              ld_sync_i,
  input  logic              ce_sync_i,
  output logic [CW-1:0]     count_o,
  output logic [CW-1:0]     max_o,
  output logic [CW-1:0]     ont_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              out_o,
  output logic              tc_c_o
);

  logic [CW-1:0] count_q, count_d, max_q, max_d, ont_q, ont_d;
  logic          ce_q, ce_d, ar_q, ar_d, xc_q, xc_d, ge_q, ge_d, out_q, out_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    xs_q, gs_q;
  logic          x_pe_c, g_pe_c, gate_lvl_c, retrig_c, reload_c, tick_c, ld_c, tc_c;

  // Two sync flops then a previous-value flop for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xs_q <= '0;
      gs_q <= '0;
    end else begin
      xs_q <= {xs_q[1:0], clk_x_i};
      gs_q <= {gs_q[1:0], gate_i};
    end
  end

  assign x_pe_c     = xs_q[1] & ~xs_q[2];
  assign g_pe_c     = gs_q[1] & ~gs_q[2];
  assign gate_lvl_c = gs_q[1];
  assign retrig_c   = (mode_q == PM_RETRIG);
  // Mode 11 falls back to continuous behaviour
  assign reload_c   = ar_q & (mode_q != PM_ONESHOT) & (mode_q != PM_RETRIG);
  // Retrigger mode uses the gate edge only, never the level
  assign tick_c     = ce_q & (~xc_q | x_pe_c) & (~ge_q | retrig_c | gate_lvl_c);
  assign ld_c       = (wr_ctrl_i & wdat_ctrl_i[CTRL_LD]) | ld_sync_i;

  // Counter next state; bus writes applied last so they override internal updates
  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    ont_d   = ont_q;
    ce_d    = ce_q;
    ar_d    = ar_q;
    xc_d    = xc_q;
    ge_d    = ge_q;
    mode_d  = mode_q;
    out_d   = out_q;
    tc_c    = 1'b0;
    if (ld_c) begin
      count_d = max_q;
    end else if (retrig_c && g_pe_c) begin
      count_d = max_q;
      ce_d    = 1'b1;
    end else if (tick_c) begin
      if (count_q == ont_q) out_d = 1'b1;
      if (count_q == '0) begin
        out_d = 1'b0;
        tc_c  = 1'b1;
        if (reload_c) count_d = max_q;
        else          ce_d    = 1'b0;
      end else begin
        count_d = count_q - CW'(1);
      end
    end
    if (wr_max_i) max_d = wdat_max_i;
    if (wr_ont_i) ont_d = wdat_ont_i;
    if (wr_ctrl_i) begin
      ce_d   = wdat_ctrl_i[CTRL_CE];
      ar_d   = wdat_ctrl_i[CTRL_AR];
      xc_d   = wdat_ctrl_i[CTRL_XC];
      ge_d   = wdat_ctrl_i[CTRL_GE];
      mode_d = wdat_ctrl_i[CTRL_MODE_HI:CTRL_MODE_LO];
    end
    if (ce_sync_i) ce_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      max_q   <= '0;
      ont_q   <= '0;
      ce_q    <= 1'b0;
      ar_q    <= 1'b1;
      xc_q    <= 1'b0;
      ge_q    <= 1'b0;
      mode_q  <= 2'b00;
      out_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      ont_q   <= ont_d;
      ce_q    <= ce_d;
      ar_q    <= ar_d;
      xc_q    <= xc_d;
      ge_q    <= ge_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign count_o = count_q;
  assign max_o   = max_q;
  assign ont_o   = ont_q;
  assign ctrl_o  = {mode_q, ge_q, xc_q, ar_q, ce_q, 1'b0};
  assign out_o   = out_q;
  assign tc_c_o  = tc_c;

endmodule

// File: rtl/rtfitanium_pitn.sv
// Programmable interval timer top: bus decode, read mux, global registers.
// Ports:
//   clk_i/rst_ni                       clock, async active-low reset
//   cs_i/cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   slave bus request
//   ack_o                              write: same cycle; read: one cycle later
//   dat_o                              registered read data
//   clk_x/gate                         per-channel asynchronous inputs
//   out                                per-channel outputs
//   irq_o                              registered OR of enabled irq status
module rtfitanium_pitn
  import rtfitanium_pitn_pkg::*;
#(
  parameter int unsigned NCH = 3,
  parameter int unsigned CW  = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           cs_i,
  input  logic           cyc_i,
  input  logic           stb_i,
  output logic           ack_o,
  input  logic           we_i,
  input  logic [3:0]     sel_i,
  input  logic [7:0]     adr_i,
  input  logic [31:0]    dat_i,
  output logic [31:0]    dat_o,
  input  logic [NCH-1:0] clk_x,
  input  logic [NCH-1:0] gate,
  output logic [NCH-1:0] out,
  output logic           irq_o
);

  logic              cs_c, wr_c;
  logic [7:0]        adr_w;
  logic [31:0]       rd_c, dat_o_q;
  logic              rd_ack_q, irq_o_q;
  logic [NCH-1:0]    irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, w1c_c;
  logic [NCH-1:0]    hit, wr_max, wr_ont, wr_ctrl, sync_ld, sync_ce, ch_tc;
  logic [CW-1:0]     ch_cnt [NCH];
  logic [CW-1:0]     ch_max [NCH];
  logic [CW-1:0]     ch_ont [NCH];
  logic [CTRL_W-1:0] ch_ctrl [NCH];
  logic              wr_irqs, wr_irqe, wr_sync;

  assign cs_c  = cs_i & cyc_i & stb_i;
  assign wr_c  = cs_c & we_i;
  assign adr_w = {adr_i[7:2], 2'b00};
  assign ack_o = cs_c & (we_i | rd_ack_q);

  assign wr_irqs = wr_c & (adr_w == PIT_IRQS);
  assign wr_irqe = wr_c & (adr_w == PIT_IRQE);
  assign wr_sync = wr_c & (adr_w == PIT_SYNC);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    assign hit[n]     = ~adr_w[7] & (adr_w[6:4] == 3'(n));
    assign wr_max[n]  = wr_c & hit[n] & (adr_w[3:0] == PIT_MAX);
    assign wr_ont[n]  = wr_c & hit[n] & (adr_w[3:0] == PIT_ONT);
    assign wr_ctrl[n] = wr_c & hit[n] & (adr_w[3:0] == PIT_CTRL);
    assign sync_ld[n] = wr_sync & sel_i[0] & dat_i[n];
    assign sync_ce[n] = wr_sync & sel_i[1] & dat_i[8+n];

    rtfitanium_pitn_chan #(.CW(CW)) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clk_x_i    (clk_x[n]),
      .gate_i     (gate[n]),
      .wr_max_i   (wr_max[n]),
      .wr_ont_i   (wr_ont[n]),
      .wr_ctrl_i  (wr_ctrl[n]),
      .wdat_max_i (CW'(byte_merge(32'(ch_max[n]), dat_i, sel_i))),
      .wdat_ont_i (CW'(byte_merge(32'(ch_ont[n]), dat_i, sel_i))),
      .wdat_ctrl_i(CTRL_W'(byte_merge(32'(ch_ctrl[n]), dat_i, sel_i))),
      .ld_sync_i  (sync_ld[n]),
      .ce_sync_i  (sync_ce[n]),
      .count_o    (ch_cnt[n]),
      .max_o      (ch_max[n]),
      .ont_o      (ch_ont[n]),
      .ctrl_o     (ch_ctrl[n]),
      .out_o      (out[n]),
      .tc_c_o     (ch_tc[n])
    );
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_c = '0;
    for (int n = 0; n < NCH; n++) begin
      if (hit[n]) begin
        unique case (adr_w[3:0])
          PIT_CNT:  rd_c = 32'(ch_cnt[n]);
          PIT_MAX:  rd_c = 32'(ch_max[n]);
          PIT_ONT:  rd_c = 32'(ch_ont[n]);
          PIT_CTRL: rd_c = 32'(ch_ctrl[n]);
          default:  rd_c = '0;
        endcase
      end
    end
    if (adr_w == PIT_IRQS) rd_c = 32'(irq_stat_q);
    if (adr_w == PIT_IRQE) rd_c = 32'(irq_en_q);
  end

  // Terminal-count set wins over a same-cycle write-1-to-clear
  always_comb begin
    w1c_c      = wr_irqs ? NCH'(byte_merge(32'h0, dat_i, sel_i)) : '0;
    irq_stat_d = (irq_stat_q & ~w1c_c) | ch_tc;
    irq_en_d   = wr_irqe ? NCH'(byte_merge(32'(irq_en_q), dat_i, sel_i)) : irq_en_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ack_q   <= 1'b0;
      dat_o_q    <= '0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_o_q    <= 1'b0;
    end else begin
      rd_ack_q   <= cs_c & ~we_i;
      if (cs_c && !we_i) dat_o_q <= rd_c;
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_o_q    <= |(irq_stat_q & irq_en_q);
    end
  end

  assign dat_o = dat_o_q;
  assign irq_o = irq_o_q;

endmodule

// File: tb/tb_rtfitanium_pitn.sv
// Self-checking bench for rtfitanium_pitn: read expectations go into a
// scoreboard queue and a negedge monitor compares them when a read is acked.
module tb_rtfitanium_pitn;

  localparam int unsigned NCH = 3;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           cs_i, cyc_i, stb_i, we_i;
  logic [3:0]     sel_i;
  logic [7:0]     adr_i;
  logic [31:0]    dat_i;
  logic           ack_o;
  logic [31:0]    dat_o;
  logic [NCH-1:0] clk_x, gate, out;
  logic           irq_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  adr;
    logic [31:0] exp;
  } rd_exp_t;
  rd_exp_t sb[$];

  rtfitanium_pitn #(.NCH(NCH), .CW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
    .ack_o(ack_o), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_o), .clk_x(clk_x), .gate(gate), .out(out), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Read-data monitor
  always @(negedge clk_i) begin
    if (cs_i && cyc_i && stb_i && !we_i && ack_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got ack adr %h want no ack", adr_i);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd_%h", e.adr), dat_o, e.exp);
      end
    end
  end

  // All bus tasks start and return just after a rising edge
  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = a; dat_i = d; sel_i = s;
    #1 chk("wr_ack", 32'(ack_o), 32'd1);
    @(posedge clk_i); #1;
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_wr(a, d, 4'hF);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    logic got;
    sb.push_back('{adr: a, exp: e});
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    adr_i = a; sel_i = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i); #1;
      got = ack_o;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL rd_ack_timeout: got no ack adr %h want ack", a);
      void'(sb.pop_back());
    end
    @(negedge clk_i); #1;
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic xpulse(input int ch);
    clk_x[ch] = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 clk_x[ch] = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic gpulse(input int ch);
    gate[ch] = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 gate[ch] = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  int          exp_cnt [6] = '{4, 3, 2, 1, 0, 5};
  logic [31:0] exp_out [6] = '{0, 0, 0, 1, 1, 0};

  initial begin
    rst_ni = 1'b0;
    cs_i = 0; cyc_i = 0; stb_i = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
    clk_x = '0; gate = '0;
    #12;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    rd(8'h0C, 32'h04);
    rd(8'h00, 32'h0);

    // Continuous mode on ch0, clocked from clk_x[0]
    wr(8'h04, 32'd5);
    wr(8'h08, 32'd2);
    wr(8'h0C, 32'h0E);
    wr(8'h84, 32'h1);
    wr(8'h88, 32'h1);
    rd(8'h00, 32'd5);
    rd(8'h0C, 32'h0E);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) rd(8'h80, 32'h0);
      xpulse(0);
      chk($sformatf("cont_out_%0d", i), 32'(out[0]), exp_out[i]);
      rd(8'h00, 32'(exp_cnt[i]));
    end
    rd(8'h80, 32'h1);
    chk("cont_irq", 32'(irq_o), 32'd1);

    // One-shot on ch0
    wr(8'h0C, 32'h0);
    wr(8'h80, 32'h1);
    wr(8'h04, 32'd3);
    wr(8'h0C, 32'h2B);
    rd(8'h00, 32'd3);
    rd(8'h0C, 32'h2A);
    for (int i = 0; i < 3; i++) begin
      xpulse(0);
      rd(8'h00, 32'(2 - i));
    end
    xpulse(0);
    rd(8'h00, 32'd0);
    rd(8'h0C, 32'h28);
    rd(8'h80, 32'h1);
    chk("os_irq", 32'(irq_o), 32'd1);
    xpulse(0);
    rd(8'h00, 32'd0);
    wr(8'h04, 32'd9);
    rd(8'h00, 32'd0);
    wr(8'h80, 32'h1);
    @(posedge clk_i); #1;
    chk("os_irq_clr", 32'(irq_o), 32'd0);
    rd(8'h80, 32'h0);

    // Gate-retrigger on ch1, ticks from clk_x[1]
    wr(8'h14, 32'd4);
    wr(8'h1C, 32'h58);
    rd(8'h1C, 32'h58);
    gpulse(1);
    rd(8'h10, 32'd4);
    rd(8'h1C, 32'h5A);
    xpulse(1);
    xpulse(1);
    rd(8'h10, 32'd2);
    gpulse(1);
    rd(8'h10, 32'd4);
    for (int i = 0; i < 4; i++) xpulse(1);
    rd(8'h10, 32'd0);
    rd(8'h80, 32'h0);
    xpulse(1);
    rd(8'h80, 32'h2);
    rd(8'h1C, 32'h58);
    chk("rt_irq_masked", 32'(irq_o), 32'd0);
    wr(8'h80, 32'h2);

    // External clock latency on ch2, with a byte-lane write of max
    wr(8'h24, 32'h0);
    bus_wr(8'h24, 32'hAABBCC64, 4'b0001);
    rd(8'h24, 32'h64);
    wr(8'h2C, 32'h0A);
    wr(8'h88, 32'h4);
    rd(8'h20, 32'd100);
    @(posedge clk_i); #1 clk_x[2] = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    rd(8'h20, 32'd100);
    repeat (4) @(posedge clk_i); #1 clk_x[2] = 1'b0;
    repeat (8) @(posedge clk_i); #1 clk_x[2] = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    rd(8'h20, 32'd98);
    repeat (30) @(posedge clk_i); #1;
    rd(8'h20, 32'd98);
    for (int i = 0; i < 3; i++) begin
      clk_x[2] = 1'b0;
      repeat (8) @(posedge clk_i); #1;
      clk_x[2] = 1'b1;
      repeat (8) @(posedge clk_i); #1;
    end
    rd(8'h20, 32'd95);

    // Synchronous load/start of all channels, internal clock
    wr(8'h0C, 32'h04);
    wr(8'h1C, 32'h04);
    wr(8'h2C, 32'h04);
    wr(8'h04, 32'd10);
    wr(8'h14, 32'd20);
    wr(8'h24, 32'd30);
    wr(8'h88, 32'h0000_0707);
    @(posedge clk_i); #1;
    rd(8'h00, 32'd9);
    rd(8'h10, 32'd17);
    rd(8'h20, 32'd25);
    repeat (10) @(posedge clk_i); #1;
    chk("sync_irq", 32'(irq_o), 32'd1);

    // Asynchronous reset mid-count
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_irq", 32'(irq_o), 32'd0);
    chk("mid_rst_dat", dat_o, 32'd0);
    chk("mid_rst_ack", 32'(ack_o), 32'd0);
    repeat (2) @(posedge clk_i); #1 rst_ni = 1'b1;
    rd(8'h00, 32'd0);
    rd(8'h0C, 32'h04);
    rd(8'h90, 32'h0);
    rd(8'h80, 32'h0);
    rd(8'h14, 32'h0);
    repeat (5) @(posedge clk_i); #1;
    rd(8'h00, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
